// File: rtl/vmask_pop_first_if.sv
// Beat/result bundle for the vcpop.m / vfirst.m mask-reduction unit.
// in_valid qualifies a beat and has no ready: every valid beat is taken; out_valid pulses one cycle per new out_vec.
interface vmask_pop_first_if #(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int OPSEL_WIDTH     = 1
);
    localparam int CW = $clog2(REQ_DATA_WIDTH) + 1;

    logic                       in_valid;
    logic [REQ_DATA_WIDTH-1:0]  in_m0;
    logic [REQ_DATA_WIDTH-1:0]  in_vmask;
    logic                       in_masked;
    logic [CW-1:0]              in_elem;
    logic                       in_start;
    logic                       in_last;
    logic [OPSEL_WIDTH-1:0]     in_opsel;
    logic [RESP_DATA_WIDTH-1:0] out_vec;
    logic                       out_valid;

    modport master (
        output in_valid, in_m0, in_vmask, in_masked, in_elem, in_start, in_last, in_opsel,
        input  out_vec, out_valid
    );

    modport slave (
        input  in_valid, in_m0, in_vmask, in_masked, in_elem, in_start, in_last, in_opsel,
        output out_vec, out_valid
    );
endinterface

// File: rtl/vmask_pop_first.sv
// Multi-beat vcpop.m / vfirst.m reduction: per-beat masking, pipelined popcount tree,
// lowest-set-bit search, and cross-beat accumulation into a scalar result.
module vmask_pop_first #(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int OPSEL_WIDTH     = 1
) (
    input  logic             clk,
    input  logic             rst,
    vmask_pop_first_if.slave io_bus
);
    localparam int W  = REQ_DATA_WIDTH;
    localparam int RW = RESP_DATA_WIDTH;
    localparam int S  = $clog2(W);
    localparam int IW = $clog2(W);
    localparam int CW = IW + 1;

    logic [CW-1:0] w_elem;
    logic [W-1:0]  w_tail;
    logic [W-1:0]  w_eff;
    logic [IW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        w_elem = (io_bus.in_elem > CW'(W)) ? CW'(W) : io_bus.in_elem;
        for (int i = 0; i < W; i++) begin
            w_tail[i] = (CW'(i) < w_elem);
        end
        w_eff   = io_bus.in_m0 & (io_bus.in_masked ? io_bus.in_vmask : '1) & w_tail;
        w_idx   = '0;
        w_found = 1'b0;
        // Descending scan so the lowest set bit is the last one written.
        for (int i = W - 1; i >= 0; i--) begin
            if (w_eff[i]) begin
                w_idx   = IW'(i);
                w_found = 1'b1;
            end
        end
    end

    // Per-beat side band; index k is aligned with tree stage k.
    logic [S-1:0]                  r_vld;
    logic [S-1:0]                  r_st;
    logic [S-1:0]                  r_ls;
    logic [S-1:0]                  r_fnd;
    logic [S-1:0][OPSEL_WIDTH-1:0] r_op;
    logic [S-1:0][IW-1:0]          r_idx;
    logic [W-1:0]                  r_eff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_st  <= '0;
            r_ls  <= '0;
            r_fnd <= '0;
            r_op  <= '0;
            r_idx <= '0;
            r_eff <= '0;
        end else begin
            r_vld[0] <= io_bus.in_valid;
            r_st[0]  <= io_bus.in_start;
            r_ls[0]  <= io_bus.in_last;
            r_fnd[0] <= w_found;
            r_op[0]  <= io_bus.in_opsel;
            r_idx[0] <= w_idx;
            r_eff    <= w_eff;
            for (int k = 1; k < S; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_st[k]  <= r_st[k-1];
                r_ls[k]  <= r_ls[k-1];
                r_fnd[k] <= r_fnd[k-1];
                r_op[k]  <= r_op[k-1];
                r_idx[k] <= r_idx[k-1];
            end
        end
    end

    // Stage k holds W>>k partial sums, each k+1 bits wide.
    for (genvar k = 1; k < S; k++) begin : g_tree
        localparam int N = W >> k;
        localparam int B = k + 1;
        logic [N*B-1:0] w_sum;
        logic [N*B-1:0] r_sum;

        for (genvar j = 0; j < N; j++) begin : g_add
            if (k == 1) begin : g_leaf
                assign w_sum[j*B +: B] = {1'b0, r_eff[2*j]} + {1'b0, r_eff[2*j+1]};
            end else begin : g_node
                assign w_sum[j*B +: B] = {1'b0, g_tree[k-1].r_sum[2*j*(B-1) +: B-1]}
                                       + {1'b0, g_tree[k-1].r_sum[(2*j+1)*(B-1) +: B-1]};
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_sum <= '0;
            else     r_sum <= w_sum;
        end
    end

    logic [CW-1:0] w_pcnt;

    if (S == 1) begin : g_pcnt_leaf
        assign w_pcnt = CW'(r_eff[0]) + CW'(r_eff[1]);
    end else begin : g_pcnt_node
        assign w_pcnt = {1'b0, g_tree[S-1].r_sum[S-1:0]} + {1'b0, g_tree[S-1].r_sum[2*S-1:S]};
    end

    logic [RW-1:0] r_cnt;
    logic [RW-1:0] r_first;
    logic [RW-1:0] r_base;
    logic          r_have;
    logic [RW-1:0] r_out_vec;
    logic          r_out_valid;

    logic [RW-1:0] w_pos;
    logic [RW-1:0] w_cnt_nx;
    logic [RW-1:0] w_first_nx;
    logic          w_have_nx;

    always_comb begin
        w_pos = (r_base << IW) | RW'(r_idx[S-1]);
        if (r_st[S-1]) begin
            w_cnt_nx   = RW'(w_pcnt);
            w_have_nx  = r_fnd[S-1];
            w_first_nx = r_fnd[S-1] ? RW'(r_idx[S-1]) : '1;
        end else begin
            w_cnt_nx   = r_cnt + RW'(w_pcnt);
            w_have_nx  = r_have | r_fnd[S-1];
            w_first_nx = (!r_have && r_fnd[S-1]) ? w_pos : r_first;
        end
    end

    // Bubbles (r_vld low) leave the accumulator and beat counter untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_first     <= '0;
            r_base      <= '0;
            r_have      <= 1'b0;
            r_out_vec   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_vld[S-1] & r_ls[S-1];
            if (r_vld[S-1]) begin
                r_cnt   <= w_cnt_nx;
                r_first <= w_first_nx;
                r_have  <= w_have_nx;
                r_base  <= r_st[S-1] ? RW'(1) : r_base + RW'(1);
                if (r_ls[S-1]) begin
                    r_out_vec <= (r_op[S-1] != '0) ? w_first_nx : w_cnt_nx;
                end
            end
        end
    end

    assign io_bus.out_vec   = r_out_vec;
    assign io_bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_vmask_pop_first.sv
// Directed bench for vmask_pop_first at W=8: single-beat vector table plus multi-beat,
// bubble, reset and wrap sequences; results matched by value and arrival cycle.
module tb_vmask_pop_first;
    localparam int W  = 8;
    localparam int RW = 16;
    localparam int S  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vmask_pop_first_if #(.REQ_DATA_WIDTH(W), .RESP_DATA_WIDTH(RW), .OPSEL_WIDTH(1)) bus ();
    vmask_pop_first_if #(.REQ_DATA_WIDTH(W), .RESP_DATA_WIDTH(4),  .OPSEL_WIDTH(1)) bus4 ();

    vmask_pop_first #(.REQ_DATA_WIDTH(W), .RESP_DATA_WIDTH(RW), .OPSEL_WIDTH(1)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    vmask_pop_first #(.REQ_DATA_WIDTH(W), .RESP_DATA_WIDTH(4), .OPSEL_WIDTH(1)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus4)
    );

    logic [RW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    string         name_q[$];

    typedef struct {
        logic [7:0]  m0;
        logic [7:0]  vm;
        logic        msk;
        logic [3:0]  elem;
        logic        op;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Caller sits on a negedge; returns on the negedge after the capturing posedge.
    task automatic beat(input logic [7:0] m0, input logic [7:0] vm, input logic msk,
                        input logic [3:0] elem, input logic st, input logic ls,
                        input logic op, input logic [15:0] exp, input string name);
        bus.in_valid  = 1'b1;
        bus.in_m0     = m0;
        bus.in_vmask  = vm;
        bus.in_masked = msk;
        bus.in_elem   = elem;
        bus.in_start  = st;
        bus.in_last   = ls;
        bus.in_opsel  = op;
        @(negedge clk);
        if (ls) begin
            exp_q.push_back(exp);
            exp_cyc_q.push_back(cyc + S);
            name_q.push_back(name);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        bus.in_last  = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    // Scoreboard: each pulse must match the oldest pending result in value and cycle.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse got out_vec=%0h at cycle %0d want no pulse", bus.out_vec, cyc);
            end else begin
                automatic logic [RW-1:0] ev = exp_q.pop_front();
                automatic int            ec = exp_cyc_q.pop_front();
                automatic string         nm = name_q.pop_front();
                check({nm, "_vec"}, bus.out_vec, ev);
                check({nm, "_cycle"}, cyc, ec);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{8'hFF, 8'h00, 1'b0, 4'd8,  1'b0, 16'd8};
        tbl[1]  = '{8'hFF, 8'h0F, 1'b1, 4'd3,  1'b0, 16'd3};
        tbl[2]  = '{8'hFF, 8'h0F, 1'b1, 4'd3,  1'b1, 16'd0};
        tbl[3]  = '{8'h00, 8'hFF, 1'b0, 4'd8,  1'b1, 16'hFFFF};
        tbl[4]  = '{8'h80, 8'h00, 1'b0, 4'd8,  1'b1, 16'd7};
        tbl[5]  = '{8'h80, 8'h00, 1'b0, 4'd7,  1'b1, 16'hFFFF};
        tbl[6]  = '{8'hA5, 8'hFF, 1'b0, 4'd0,  1'b0, 16'd0};
        tbl[7]  = '{8'hA5, 8'h3C, 1'b1, 4'd15, 1'b0, 16'd2};
        tbl[8]  = '{8'hA5, 8'h3C, 1'b1, 4'd15, 1'b1, 16'd2};
        tbl[9]  = '{8'hF0, 8'h00, 1'b0, 4'd8,  1'b0, 16'd4};
        tbl[10] = '{8'h6C, 8'hF0, 1'b1, 4'd6,  1'b1, 16'd5};

        bus.in_valid = 0; bus.in_m0 = 0; bus.in_vmask = 0; bus.in_masked = 0;
        bus.in_elem = 0; bus.in_start = 0; bus.in_last = 0; bus.in_opsel = 0;
        bus4.in_valid = 0; bus4.in_m0 = 0; bus4.in_vmask = 0; bus4.in_masked = 0;
        bus4.in_elem = 0; bus4.in_start = 0; bus4.in_last = 0; bus4.in_opsel = 0;

        repeat (2) @(negedge clk);
        check("reset_out_vec", bus.out_vec, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_vec4", bus4.out_vec, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single-beat instructions, issued back to back.
        for (int i = 0; i < 11; i++) begin
            beat(tbl[i].m0, tbl[i].vm, tbl[i].msk, tbl[i].elem, 1'b1, 1'b1, tbl[i].op,
                 tbl[i].exp, $sformatf("tbl%0d", i));
        end
        idle();
        drain("tbl_drain");
        repeat (3) @(negedge clk);
        check("hold_out_vec", bus.out_vec, 16'd5);
        check("hold_out_valid_low", bus.out_valid, 0);

        // Multi-beat; opsel taken from the last beat only.
        beat(8'h00, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 16'd0,  "mb_first");
        beat(8'h00, 8'h00, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 16'd0,  "mb_first");
        beat(8'h10, 8'h00, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1, 16'd20, "mb_first");
        beat(8'h00, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 16'd0,  "mb_count");
        beat(8'h00, 8'h00, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 16'd0,  "mb_count");
        beat(8'h10, 8'h00, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0, 16'd1,  "mb_count");
        beat(8'h00, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 16'd0,  "mb_none");
        beat(8'h00, 8'h00, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 16'd0,  "mb_none");
        beat(8'h00, 8'h00, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1, 16'hFFFF, "mb_none");
        idle();
        drain("mb_drain");

        // Bubble inside A, then B immediately after A's last beat.
        beat(8'h03, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 16'd0, "b2b_a");
        idle();
        beat(8'h01, 8'h00, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0, 16'd3, "b2b_a");
        beat(8'hF0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b1, 1'b0, 16'd4, "b2b_b");
        idle();
        drain("b2b_drain");

        // Empty beat (elem 0) still advances the beat base.
        beat(8'hFF, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 16'd0, "elem0_base");
        beat(8'h01, 8'h00, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1, 16'd8, "elem0_base");
        idle();
        drain("elem0_drain");

        // Reset mid-instruction: asynchronous clear, in-flight beat discarded.
        beat(8'hFF, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 16'd0, "rst_mid");
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async_out_vec", bus.out_vec, 0);
        check("rst_async_out_valid", bus.out_valid, 0);
        @(negedge clk);
        check("rst_hold_out_vec", bus.out_vec, 0);
        rst = 1'b0;
        beat(8'h01, 8'h00, 1'b0, 4'd8, 1'b1, 1'b1, 1'b0, 16'd1, "rst_after");
        idle();
        drain("rst_drain");

        // Narrow result: 24 set bits wrap to 8 in a 4-bit counter.
        for (int b = 0; b < 3; b++) begin
            bus4.in_valid = 1'b1;
            bus4.in_m0    = 8'hFF;
            bus4.in_elem  = 4'd8;
            bus4.in_start = (b == 0);
            bus4.in_last  = (b == 2);
            bus4.in_opsel = 1'b0;
            @(negedge clk);
        end
        bus4.in_valid = 1'b0;
        bus4.in_last  = 1'b0;
        for (int k = 1; k < S; k++) begin
            @(negedge clk);
            check("wrap_early_valid", bus4.out_valid, 0);
        end
        @(negedge clk);
        check("wrap_valid", bus4.out_valid, 1);
        check("wrap_vec", bus4.out_vec, 4'd8);
        @(negedge clk);
        check("wrap_pulse_end", bus4.out_valid, 0);

        repeat (5) @(negedge clk);
        drain("final_drain");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
